// File: rtl/vif_stream_fifo_if.sv
// Valid/ready byte-stream bundle shared by the case-select producer and its consumers.
// The master drives data/valid, the slave drives ready.
interface vif_stream_fifo_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/vif_stream_fifo.sv
// Circular FIFO that buffers an upstream valid/ready stream and re-presents it downstream,
// reporting occupancy and a wrapping count of accepted words.
module vif_stream_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned LVL_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  vif_stream_fifo_if.slave     in_if,
  vif_stream_fifo_if.master    out_if,
  output logic [LVL_W-1:0]     level,
  output logic [CNT_W-1:0]     accepted_count
);

  localparam logic [LVL_W-1:0] LevelFull = LVL_W'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_depth_check
    $error("vif_stream_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              in_ready;
  logic              out_valid;
  logic              push;
  logic              pop;

  // Handshakes decode from the registered level only, so full never bypasses a same-cycle pop.
  always_comb begin
    in_ready  = (level != LevelFull);
    out_valid = (level != '0);
    push      = in_if.valid && in_ready;
    pop       = out_valid && out_if.ready;
  end

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      accepted_count <= '0;
    end else begin
      if (push) begin
        wr_ptr         <= wr_ptr + PTR_W'(1);
        accepted_count <= accepted_count + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        level <= level + LVL_W'(1);
      end else if (pop && !push) begin
        level <= level - LVL_W'(1);
      end
    end
  end

  // Storage is deliberately left out of reset; level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_if.data;
    end
  end

endmodule

// File: tb/tb_vif_stream_fifo.sv
// Scoreboard bench for vif_stream_fifo: drivers queue expected words, a negedge monitor
// checks every downstream pop against the queue head.
module tb_vif_stream_fifo;

  logic clk;
  logic rst;
  logic [2:0]  level;
  logic [15:0] accepted_count;

  int checks;
  int errors;
  logic [7:0] exp_q [$];

  vif_stream_fifo_if #(.DATA_W(8)) in_if ();
  vif_stream_fifo_if #(.DATA_W(8)) out_if ();

  vif_stream_fifo #(
    .DATA_W(8),
    .DEPTH (4),
    .CNT_W (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_if         (in_if),
    .out_if        (out_if),
    .level         (level),
    .accepted_count(accepted_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one word for one cycle; the hand-planned stimulus expects it to be accepted.
  task automatic push(input logic [7:0] d);
    in_if.valid = 1'b1;
    in_if.data  = d;
    @(negedge clk);
    check("push_accept", {31'd0, in_if.ready}, 32'd1);
    exp_q.push_back(d);
    step();
    in_if.valid = 1'b0;
    in_if.data  = 8'hxx;
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    exp_q.delete();
  endtask

  // Monitor: a pop happens at the next rising edge whenever valid && ready here.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_if.valid && out_if.ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got %0h expected none", out_if.data);
        end else begin
          check("pop_data", {24'd0, out_if.data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    in_if.valid  = 1'b0;
    in_if.data   = 8'h00;
    out_if.ready = 1'b0;

    // Reset state
    #1;
    check("rst_out_valid", {31'd0, out_if.valid}, 32'd0);
    check("rst_out_data", {24'd0, out_if.data}, 32'h00);
    check("rst_in_ready", {31'd0, in_if.ready}, 32'd1);
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_count", {16'd0, accepted_count}, 32'd0);
    #1 rst = 1'b0;
    step();

    // Single word
    push(8'hAA);
    check("single_valid", {31'd0, out_if.valid}, 32'd1);
    check("single_data", {24'd0, out_if.data}, 32'hAA);
    check("single_level", {29'd0, level}, 32'd1);
    out_if.ready = 1'b1;
    step();
    out_if.ready = 1'b0;
    check("single_level_after_pop", {29'd0, level}, 32'd0);
    check("single_empty_data", {24'd0, out_if.data}, 32'h00);

    // Fill and stall
    pulse_reset();
    step();
    for (int i = 1; i <= 4; i++) push(8'(i));
    check("full_level", {29'd0, level}, 32'd4);
    check("full_in_ready", {31'd0, in_if.ready}, 32'd0);
    check("full_count", {16'd0, accepted_count}, 32'd4);
    in_if.valid = 1'b1;
    in_if.data  = 8'h05;
    @(negedge clk);
    check("full_reject_ready", {31'd0, in_if.ready}, 32'd0);
    step();
    in_if.valid = 1'b0;
    check("full_reject_count", {16'd0, accepted_count}, 32'd4);
    check("full_reject_level", {29'd0, level}, 32'd4);
    check("full_head", {24'd0, out_if.data}, 32'h01);
    out_if.ready = 1'b1;
    step();
    check("full_pop_in_ready", {31'd0, in_if.ready}, 32'd1);
    repeat (3) step();
    out_if.ready = 1'b0;
    check("drain_level", {29'd0, level}, 32'd0);
    check("drain_queue_empty", exp_q.size(), 32'd0);

    // Wrap with simultaneous push and pop, level held at 2
    push(8'h0E);
    push(8'h0F);
    check("wrap_setup_level", {29'd0, level}, 32'd2);
    out_if.ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(8'h10 + 8'(i));
      check("wrap_level", {29'd0, level}, 32'd2);
    end
    check("wrap_count", {16'd0, accepted_count}, 32'd16);
    repeat (2) step();
    out_if.ready = 1'b0;
    check("wrap_drain_level", {29'd0, level}, 32'd0);
    check("wrap_queue_empty", exp_q.size(), 32'd0);

    // Mid-operation reset
    push(8'h20);
    push(8'h21);
    push(8'h22);
    check("mid_level", {29'd0, level}, 32'd3);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, out_if.valid}, 32'd0);
    check("mid_rst_level", {29'd0, level}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_if.ready}, 32'd1);
    check("mid_rst_data", {24'd0, out_if.data}, 32'h00);
    #1 rst = 1'b0;
    exp_q.delete();
    step();
    push(8'h55);
    check("post_rst_data", {24'd0, out_if.data}, 32'h55);
    check("post_rst_count", {16'd0, accepted_count}, 32'd1);
    out_if.ready = 1'b1;
    step();

    // Counter wrap
    pulse_reset();
    step();
    for (int i = 0; i < 65535; i++) push(8'(i));
    check("cnt_all_ones", {16'd0, accepted_count}, 32'hFFFF);
    push(8'hC3);
    check("cnt_wrap", {16'd0, accepted_count}, 32'h0000);
    repeat (2) step();
    out_if.ready = 1'b0;
    check("cnt_level", {29'd0, level}, 32'd0);
    check("cnt_queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
